// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: synchronises the pin strobe, serialises bytes LSB-first into the fabric
// config chain and enables the fabric once CHAIN_LEN bits are loaded. Optional CRC: CFG_CRC_EN.
module fpga_cfg_loader #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_stb,
    input  logic       restart,
    output logic       ready,
    output logic       cfg_data,
    output logic       cfg_shift,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic       fabric_en
);

`ifdef CFG_CRC_EN
    typedef enum logic [2:0] {StIdle, StShift, StDone, StCheck, StError} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(CHAIN_LEN - 1);

    state_e           state_q, state_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shift_q, shift_d;
    logic             data_q, data_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             stb_edge;

`ifdef CFG_CRC_EN
    logic [7:0] crc_q, crc_d, crc_next;
    logic       crc_fb;

    // CRC-8 (x^8+x^2+x+1), MSB-first, advanced by the bit being shifted out this cycle
    assign crc_fb   = crc_q[7] ^ sreg_q[0];
    assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif

    assign stb_edge = sync2_q & ~sync3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= 1'b0;
            data_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
`ifdef CFG_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            sync1_q <= byte_stb;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
`ifdef CFG_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shift_d = 1'b0;
        data_d  = data_q;
`ifdef CFG_CRC_EN
        crc_d   = crc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (stb_edge) begin
                    sreg_d  = byte_in;
                    idx_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                shift_d = 1'b1;
                data_d  = sreg_q[0];
                sreg_d  = {1'b0, sreg_q[7:1]};
                idx_d   = idx_q + 3'd1;
                cnt_d   = cnt_q + CNT_W'(1);
`ifdef CFG_CRC_EN
                crc_d   = crc_next;
`endif
                // Chain-full check first so a partial last byte stops mid-byte
                if (cnt_q == LastCnt) begin
`ifdef CFG_CRC_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else if (idx_q == 3'd7) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
            end
`ifdef CFG_CRC_EN
            StCheck: begin
                if (stb_edge) begin
                    state_d = (byte_in == crc_q) ? StDone : StError;
                end
            end
            StError: begin
            end
`endif
            default: state_d = StIdle;
        endcase

        // restart overrides everything, including a coincident strobe
        if (restart) begin
            state_d = StIdle;
            cnt_d   = '0;
            shift_d = 1'b0;
`ifdef CFG_CRC_EN
            crc_d   = '0;
`endif
        end
    end

`ifdef CFG_CRC_EN
    assign ready   = (state_q == StIdle) || (state_q == StCheck);
    assign cfg_err = (state_q == StError);
`else
    assign ready   = (state_q == StIdle);
    assign cfg_err = 1'b0;
`endif
    assign cfg_done  = (state_q == StDone);
    assign fabric_en = (state_q == StDone);
    assign cfg_data  = data_q;
    assign cfg_shift = shift_q;

endmodule
